fetch_stage: RTL

Instruction-fetch stage of the MIPS core, directly upstream of the instruction memory. It owns the program counter and drives the instruction-memory byte address. It captures the returned instruction word into the IF/ID pipeline register, applying hazard-unit stalls, EX-stage branch/jump redirects, and end-of-program halt detection. It also keeps a retired-fetch counter for debug.

---
 rtl/fetch_stage.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction-memory addressing and
// captures fetched words into the IF/ID register with stall, redirect and halt handling.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] inst_in,
  output logic [31:0] pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        halted,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] PC_LIMIT = 32'(4 * MEM_WORDS);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    sat_inc = (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc4;
  logic [31:0] r_count;

  state_t      w_state_next;
  logic [31:0] w_pc_next;
  logic        w_valid_next;
  logic [31:0] w_inst_next;
  logic [31:0] w_pc4_next;
  logic [31:0] w_count_next;
  logic        w_in_range;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_redirect_target;

  assign w_in_range        = (r_pc < PC_LIMIT);
  assign w_pc_plus4        = r_pc + 32'd4;
  assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // Next-state selection: redirect beats stall and halt so a taken branch is never lost.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_valid_next = r_valid;
    w_inst_next  = r_inst;
    w_pc4_next   = r_pc4;
    w_count_next = r_count;
    if (redirect) begin
      w_state_next = ST_RUN;
      w_pc_next    = w_redirect_target;
      w_valid_next = 1'b0;
      w_inst_next  = 32'd0;
      w_pc4_next   = 32'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (stall) begin
            w_state_next = ST_RUN;
          end else if (!w_in_range) begin
            w_state_next = ST_HALT;
            w_valid_next = 1'b0;
            w_inst_next  = 32'd0;
            w_pc4_next   = 32'd0;
          end else begin
            w_pc_next    = w_pc_plus4;
            w_valid_next = 1'b1;
            w_inst_next  = inst_in;
            w_pc4_next   = w_pc_plus4;
            w_count_next = sat_inc(r_count);
          end
        end
        ST_HALT: begin
          w_valid_next = 1'b0;
          w_inst_next  = 32'd0;
          w_pc4_next   = 32'd0;
        end
        default: begin
          w_state_next = ST_RUN;
          w_valid_next = 1'b0;
          w_inst_next  = 32'd0;
          w_pc4_next   = 32'd0;
        end
      endcase
    end
  end

  // State and pipeline registers with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_inst  <= 32'd0;
      r_pc4   <= 32'd0;
      r_count <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_valid <= w_valid_next;
      r_inst  <= w_inst_next;
      r_pc4   <= w_pc4_next;
      r_count <= w_count_next;
    end
  end

  assign pc          = r_pc;
  assign if_id_valid = r_valid;
  assign if_id_inst  = r_inst;
  assign if_id_pc4   = r_pc4;
  assign halted      = (r_state == ST_HALT);
  assign fetch_count = r_count;

endmodule
